// File: rtl/gray_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : gray_updown_counter
//  Description : Prescaled up/down counter with registered binary and Gray
//                outputs, synchronous clear/load, optional saturation, and
//                one-cycle tick/wrap pulses on each step.
//  Revision    : 1.0  initial release
// ============================================================================
module gray_updown_counter #(
  parameter int CLOCK_MHZ = 16,
  parameter int BITS      = 8,
  parameter int TICK_US   = 1,
  parameter int SATURATE  = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            dir,
  input  logic            clr,
  input  logic            load,
  input  logic [BITS-1:0] load_bin,
  output logic [BITS-1:0] value,
  output logic [BITS-1:0] bin,
  output logic            tick,
  output logic            wrap
);

  // Prescaler divides the clock down to one step per TICK_US microseconds.
  localparam int              C_DIV      = CLOCK_MHZ * TICK_US;
  localparam int              C_PW       = (C_DIV > 1) ? $clog2(C_DIV) : 1;
  localparam logic [C_PW-1:0] C_PRE_LAST = C_PW'(C_DIV - 1);
  localparam logic [C_PW-1:0] C_PRE_ONE  = C_PW'(1);
  localparam logic [BITS-1:0] C_MAX      = {BITS{1'b1}};
  localparam logic [BITS-1:0] C_ONE      = BITS'(1);

  logic [C_PW-1:0] r_pre;
  logic [BITS-1:0] r_bin;
  logic [BITS-1:0] r_value;
  logic            r_tick;
  logic            r_wrap;

  logic            w_step;
  logic            w_limit;
  logic [BITS-1:0] w_next_bin;
  logic [BITS-1:0] w_next_gray;
  logic [BITS-1:0] w_load_gray;

  assign w_step      = en && (r_pre == C_PRE_LAST);
  assign w_next_gray = w_next_bin ^ (w_next_bin >> 1);
  assign w_load_gray = load_bin ^ (load_bin >> 1);

  // Next binary count for a step; flags a limit crossing or blocked step.
  always_comb begin
    w_limit    = 1'b0;
    w_next_bin = r_bin;
    if (dir) begin
      if (r_bin == C_MAX) begin
        w_limit    = 1'b1;
        w_next_bin = (SATURATE != 0) ? r_bin : '0;
      end else begin
        w_next_bin = r_bin + C_ONE;
      end
    end else begin
      if (r_bin == '0) begin
        w_limit    = 1'b1;
        w_next_bin = (SATURATE != 0) ? r_bin : C_MAX;
      end else begin
        w_next_bin = r_bin - C_ONE;
      end
    end
  end

  // Count state: clear beats load beats step; Gray copy updated on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre   <= '0;
      r_bin   <= '0;
      r_value <= '0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (clr) begin
      r_pre   <= '0;
      r_bin   <= '0;
      r_value <= '0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (load) begin
      r_pre   <= '0;
      r_bin   <= load_bin;
      r_value <= w_load_gray;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (w_step) begin
      r_pre   <= '0;
      r_bin   <= w_next_bin;
      r_value <= w_next_gray;
      r_tick  <= 1'b1;
      r_wrap  <= w_limit;
    end else begin
      if (en) begin
        r_pre <= r_pre + C_PRE_ONE;
      end
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end
  end

  assign value = r_value;
  assign bin   = r_bin;
  assign tick  = r_tick;
  assign wrap  = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_gray_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gray_updown_counter
//  Description : Directed self-checking bench for gray_updown_counter with a
//                wrapping and a saturating instance (4 MHz, 1 us, 4 bits).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gray_updown_counter;

  logic       clk = 1'b0;
  logic       rst_n, en, dir, clr, load;
  logic [3:0] load_bin;
  logic [3:0] value, bin, s_value, s_bin;
  logic       tick, wrap, s_tick, s_wrap;

  int passed = 0;
  int total  = 0;

  logic [3:0] gray_tbl [0:15] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                  4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

  always #5 clk = ~clk;

  gray_updown_counter #(.CLOCK_MHZ(4), .BITS(4), .TICK_US(1), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_bin(load_bin), .value(value), .bin(bin), .tick(tick), .wrap(wrap));

  gray_updown_counter #(.CLOCK_MHZ(4), .BITS(4), .TICK_US(1), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_bin(load_bin), .value(s_value), .bin(s_bin), .tick(s_tick), .wrap(s_wrap));

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; dir = 1'b1; clr = 1'b0; load = 1'b0; load_bin = 4'd0;
    step(); step();
    total++;
    if ({tick, wrap, bin, value} !== 10'd0) $display("FAIL reset_wrap: got %b want %b", {tick, wrap, bin, value}, 10'd0);
    else passed++;
    total++;
    if ({s_tick, s_wrap, s_bin, s_value} !== 10'd0) $display("FAIL reset_sat: got %b want %b", {s_tick, s_wrap, s_bin, s_value}, 10'd0);
    else passed++;
    rst_n = 1'b1; en = 1'b1; dir = 1'b1;
  endtask

  task automatic test_count_up();
    logic [3:0] prev, cur, sv;
    for (int k = 1; k <= 16; k++) begin
      prev = 4'((k - 1) % 16);
      cur  = 4'(k % 16);
      for (int c = 0; c < 3; c++) begin
        step();
        total++;
        if ({tick, wrap, bin, value} !== {2'b00, prev, gray_tbl[prev]})
          $display("FAIL up_idle k=%0d: got %b want %b", k, {tick, wrap, bin, value}, {2'b00, prev, gray_tbl[prev]});
        else passed++;
      end
      step();
      total++;
      if ({tick, wrap, bin, value} !== {1'b1, (k == 16), cur, gray_tbl[cur]})
        $display("FAIL up_step k=%0d: got %b want %b", k, {tick, wrap, bin, value}, {1'b1, (k == 16), cur, gray_tbl[cur]});
      else passed++;
      sv = (k >= 15) ? 4'd15 : 4'(k);
      total++;
      if ({s_tick, s_wrap, s_bin, s_value} !== {1'b1, (k == 16), sv, gray_tbl[sv]})
        $display("FAIL up_sat k=%0d: got %b want %b", k, {s_tick, s_wrap, s_bin, s_value}, {1'b1, (k == 16), sv, gray_tbl[sv]});
      else passed++;
    end
  endtask

  task automatic test_count_down();
    dir = 1'b0;
    step(); step(); step();
    total++;
    if (tick !== 1'b0) $display("FAIL down_idle: got tick=%b want 0", tick);
    else passed++;
    step();
    total++;
    if ({tick, wrap, bin, value} !== {2'b11, 4'd15, 4'b1000})
      $display("FAIL down_wrap: got %b want %b", {tick, wrap, bin, value}, {2'b11, 4'd15, 4'b1000});
    else passed++;
    total++;
    if ({s_tick, s_wrap, s_bin, s_value} !== {2'b10, 4'd14, 4'b1001})
      $display("FAIL down_sat: got %b want %b", {s_tick, s_wrap, s_bin, s_value}, {2'b10, 4'd14, 4'b1001});
    else passed++;
  endtask

  task automatic test_load();
    step(); step();
    load = 1'b1; load_bin = 4'd9;
    step();
    load = 1'b0;
    total++;
    if ({tick, wrap, bin, value} !== {2'b00, 4'd9, 4'b1101})
      $display("FAIL load_value: got %b want %b", {tick, wrap, bin, value}, {2'b00, 4'd9, 4'b1101});
    else passed++;
    total++;
    if ({s_tick, s_wrap, s_bin, s_value} !== {2'b00, 4'd9, 4'b1101})
      $display("FAIL load_sat: got %b want %b", {s_tick, s_wrap, s_bin, s_value}, {2'b00, 4'd9, 4'b1101});
    else passed++;
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if ({tick, bin} !== {1'b0, 4'd9}) $display("FAIL load_idle c=%0d: got %b want %b", c, {tick, bin}, {1'b0, 4'd9});
      else passed++;
    end
    step();
    total++;
    if ({tick, wrap, bin, value} !== {2'b10, 4'd8, 4'b1100})
      $display("FAIL load_next: got %b want %b", {tick, wrap, bin, value}, {2'b10, 4'd8, 4'b1100});
    else passed++;
  endtask

  task automatic test_clr_load();
    step();
    clr = 1'b1; load = 1'b1; load_bin = 4'd5;
    step();
    clr = 1'b0; load = 1'b0;
    total++;
    if ({tick, wrap, bin, value} !== 10'd0) $display("FAIL clr_load: got %b want %b", {tick, wrap, bin, value}, 10'd0);
    else passed++;
    step(); step(); step();
    total++;
    if ({tick, bin} !== 5'd0) $display("FAIL clr_idle: got %b want %b", {tick, bin}, 5'd0);
    else passed++;
    step();
    total++;
    if ({tick, wrap, bin, value} !== {2'b11, 4'd15, 4'b1000})
      $display("FAIL clr_next: got %b want %b", {tick, wrap, bin, value}, {2'b11, 4'd15, 4'b1000});
    else passed++;
    total++;
    if ({s_tick, s_wrap, s_bin, s_value} !== {2'b11, 4'd0, 4'd0})
      $display("FAIL sat_low: got %b want %b", {s_tick, s_wrap, s_bin, s_value}, {2'b11, 4'd0, 4'd0});
    else passed++;
  endtask

  task automatic test_saturate();
    logic [3:0] mb;
    dir = 1'b1; load = 1'b1; load_bin = 4'd15;
    step();
    load = 1'b0;
    for (int p = 1; p <= 3; p++) begin
      step(); step(); step(); step();
      total++;
      if ({s_tick, s_wrap, s_bin, s_value} !== {2'b11, 4'd15, 4'b1000})
        $display("FAIL sat_hold p=%0d: got %b want %b", p, {s_tick, s_wrap, s_bin, s_value}, {2'b11, 4'd15, 4'b1000});
      else passed++;
      mb = 4'(p - 1);
      total++;
      if ({tick, wrap, bin, value} !== {1'b1, (p == 1), mb, gray_tbl[mb]})
        $display("FAIL sat_ref p=%0d: got %b want %b", p, {tick, wrap, bin, value}, {1'b1, (p == 1), mb, gray_tbl[mb]});
      else passed++;
    end
    en = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      total++;
      if ({s_tick, s_wrap, s_bin, tick, wrap, bin} !== {2'b00, 4'd15, 2'b00, 4'd2})
        $display("FAIL freeze c=%0d: got %b want %b", c, {s_tick, s_wrap, s_bin, tick, wrap, bin}, {2'b00, 4'd15, 2'b00, 4'd2});
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    load = 1'b1; load_bin = 4'd6;
    step();
    load = 1'b0; en = 1'b1; dir = 1'b1;
    step(); step(); step(); step();
    total++;
    if ({tick, wrap, bin, value} !== {2'b10, 4'd7, 4'b0100})
      $display("FAIL pre_reset: got %b want %b", {tick, wrap, bin, value}, {2'b10, 4'd7, 4'b0100});
    else passed++;
    step(); step();
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({tick, wrap, bin, value, s_bin} !== 14'd0)
      $display("FAIL async_reset: got %b want %b", {tick, wrap, bin, value, s_bin}, 14'd0);
    else passed++;
    #2 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if ({tick, bin} !== 5'd0) $display("FAIL post_reset_idle c=%0d: got %b want %b", c, {tick, bin}, 5'd0);
      else passed++;
    end
    step();
    total++;
    if ({tick, wrap, bin, value} !== {2'b10, 4'd1, 4'b0001})
      $display("FAIL post_reset_step: got %b want %b", {tick, wrap, bin, value}, {2'b10, 4'd1, 4'b0001});
    else passed++;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_clr_load();
    test_saturate();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
